// File: rtl/lane_merge_fifo_4x8.sv
// Four per-lane FIFOs merged onto one 8-bit stream by a round-robin arbiter.
// Registered output, no fall-through; pushes into a full lane are dropped and flagged.
module lane_merge_fifo_4x8 #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = 3
) (
    input  logic       clk_f,
    input  logic       reset_L,
    input  logic [7:0] data_0_cond,
    input  logic [7:0] data_1_cond,
    input  logic [7:0] data_2_cond,
    input  logic [7:0] data_3_cond,
    input  logic       valid_0_cond,
    input  logic       valid_1_cond,
    input  logic       valid_2_cond,
    input  logic       valid_3_cond,
    input  logic       ready_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_out,
    output logic [3:0] empty,
    output logic [3:0] almost_full,
    output logic [3:0] overflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    logic [7:0]    lane_data [4];
    logic [3:0]    lane_valid;
    logic [7:0]    mem [4][DEPTH];
    logic [AW-1:0] wr_ptr [4];
    logic [AW-1:0] rd_ptr [4];
    logic [CW-1:0] count [4];
    logic [3:0]    push;
    logic [3:0]    pop;
    logic          grant_valid;
    logic [1:0]    grant_lane;
    logic [1:0]    last_grant;
    logic [1:0]    cand;

    always_comb begin
        lane_data[0] = data_0_cond;
        lane_data[1] = data_1_cond;
        lane_data[2] = data_2_cond;
        lane_data[3] = data_3_cond;
        lane_valid   = {valid_3_cond, valid_2_cond, valid_1_cond, valid_0_cond};
    end

    // Fullness is judged on the pre-edge count, so a same-edge pop never frees a slot.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            push[i]        = lane_valid[i] && (count[i] != FULL_CNT);
            empty[i]       = (count[i] == '0);
            almost_full[i] = (count[i] >= AF_CNT);
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = last_grant;
        cand        = last_grant;
        pop         = '0;
        if (ready_out) begin
            for (int unsigned k = 1; k <= 4; k++) begin
                cand = last_grant + 2'(k);
                if (!grant_valid && !empty[cand]) begin
                    grant_valid = 1'b1;
                    grant_lane  = cand;
                end
            end
        end
        if (grant_valid) pop[grant_lane] = 1'b1;
    end

    always_ff @(posedge clk_f) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= lane_data[i];
        end
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            overflow_err <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            lane_out     <= '0;
            last_grant   <= 2'd3;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
                if (lane_valid[i] && !push[i]) overflow_err[i] <= 1'b1;
            end
            valid_out <= grant_valid;
            if (grant_valid) begin
                data_out   <= mem[grant_lane][rd_ptr[grant_lane]];
                lane_out   <= grant_lane;
                last_grant <= grant_lane;
            end
        end
    end

endmodule

// File: tb/tb_lane_merge_fifo_4x8.sv
// Bench for lane_merge_fifo_4x8: queue-based lane model checked every cycle,
// plus directed sequences with literal expectations on the logged output stream.
module tb_lane_merge_fifo_4x8;

    localparam int DEPTH = 4;
    localparam int AF_THRESH = 3;

    logic       clk_f = 1'b0;
    logic       reset_L = 1'b1;
    logic [7:0] data_0_cond = '0, data_1_cond = '0, data_2_cond = '0, data_3_cond = '0;
    logic       valid_0_cond = 1'b0, valid_1_cond = 1'b0, valid_2_cond = 1'b0, valid_3_cond = 1'b0;
    logic       ready_out = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;
    logic [3:0] empty, almost_full, overflow_err;

    lane_merge_fifo_4x8 #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
        .clk_f(clk_f), .reset_L(reset_L),
        .data_0_cond(data_0_cond), .data_1_cond(data_1_cond),
        .data_2_cond(data_2_cond), .data_3_cond(data_3_cond),
        .valid_0_cond(valid_0_cond), .valid_1_cond(valid_1_cond),
        .valid_2_cond(valid_2_cond), .valid_3_cond(valid_3_cond),
        .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
        .lane_out(lane_out), .empty(empty), .almost_full(almost_full),
        .overflow_err(overflow_err)
    );

    logic clk_run = 1'b0;
    initial begin
        wait (clk_run);
        forever #5 clk_f = ~clk_f;
    end

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [1:0] lane;
        logic [7:0] data;
    } ev_t;
    ev_t out_log[$];

    // Reference model: one queue per lane, round-robin pointer as a plain integer.
    logic [7:0] mq [4][$];
    logic [3:0] m_ovf = '0;
    int         m_lg = 3;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic [1:0] m_lane = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_ovf = '0;
        m_lg = 3;
        m_valid = 1'b0;
        m_data = '0;
        m_lane = '0;
    endtask

    task automatic model_step();
        bit         full_pre [4];
        int         gl;
        logic [3:0] vin;
        logic [7:0] din [4];
        vin = {valid_3_cond, valid_2_cond, valid_1_cond, valid_0_cond};
        din[0] = data_0_cond; din[1] = data_1_cond;
        din[2] = data_2_cond; din[3] = data_3_cond;
        gl = -1;
        for (int i = 0; i < 4; i++) full_pre[i] = (mq[i].size() == DEPTH);
        if (ready_out) begin
            for (int k = 1; k <= 4; k++) begin
                int l;
                l = (m_lg + k) % 4;
                if (gl < 0 && mq[l].size() > 0) gl = l;
            end
        end
        if (gl >= 0) begin
            m_data  = mq[gl].pop_front();
            m_lane  = 2'(gl);
            m_valid = 1'b1;
            m_lg    = gl;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (vin[i]) begin
                if (full_pre[i]) m_ovf[i] = 1'b1;
                else mq[i].push_back(din[i]);
            end
        end
    endtask

    always @(negedge reset_L) model_reset();

    always @(posedge clk_f) begin
        logic [3:0] e_empty, e_af;
        cyc++;
        if (reset_L) model_step();
        #1;
        for (int i = 0; i < 4; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_af[i]    = (mq[i].size() >= AF_THRESH);
        end
        chk("valid_out", valid_out, m_valid);
        chk("data_out", data_out, m_data);
        chk("lane_out", lane_out, m_lane);
        chk("empty", empty, e_empty);
        chk("almost_full", almost_full, e_af);
        chk("overflow_err", overflow_err, m_ovf);
        if (valid_out === 1'b1) out_log.push_back('{cyc: cyc, lane: lane_out, data: data_out});
    end

    task automatic drive(input logic [3:0] vm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] e, input logic rdy);
        @(negedge clk_f);
        valid_0_cond = vm[0]; valid_1_cond = vm[1];
        valid_2_cond = vm[2]; valid_3_cond = vm[3];
        data_0_cond = a; data_1_cond = b; data_2_cond = c; data_3_cond = e;
        ready_out = rdy;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk_f);
        #2 reset_L = 1'b0;
        #5 reset_L = 1'b1;
    endtask

    task automatic chk_ev(input string nm, input int idx, input logic [1:0] l,
                          input logic [7:0] d, input int c);
        if (idx >= out_log.size()) begin
            ncmp++;
            nfail++;
            $display("FAIL %s: output %0d missing, only %0d words seen", nm, idx, out_log.size());
        end else begin
            chk({nm, "_lane"}, out_log[idx].lane, l);
            chk({nm, "_data"}, out_log[idx].data, d);
            if (c >= 0) chk({nm, "_cycle"}, out_log[idx].cyc, c);
        end
    endtask

    initial begin
        int c_push;
        logic [3:0] vm;

        // 1: asynchronous reset with no clock running
        #3 reset_L = 1'b0;
        #2;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_lane_out", lane_out, 2'd0);
        chk("rst_empty", empty, 4'hF);
        chk("rst_almost_full", almost_full, 4'h0);
        chk("rst_overflow_err", overflow_err, 4'h0);
        #3 reset_L = 1'b1;
        clk_run = 1'b1;

        // 2: single lane, latency 2 edges then back-to-back
        idle(2);
        out_log.delete();
        drive(4'b0010, 8'h00, 8'hA1, 8'h00, 8'h00, 1'b1);
        c_push = cyc + 1;
        drive(4'b0010, 8'h00, 8'hA2, 8'h00, 8'h00, 1'b1);
        drive(4'b0010, 8'h00, 8'hA3, 8'h00, 8'h00, 1'b1);
        idle(5);
        chk("t2_count", out_log.size(), 3);
        chk_ev("t2_w0", 0, 2'd1, 8'hA1, c_push + 1);
        chk_ev("t2_w1", 1, 2'd1, 8'hA2, c_push + 2);
        chk_ev("t2_w2", 2, 2'd1, 8'hA3, c_push + 3);
        chk("t2_empty1", empty[1], 1'b1);

        // 3: round-robin from a fresh reset
        pulse_reset();
        out_log.delete();
        drive(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
        idle(6);
        chk_ev("t3_w0", 0, 2'd0, 8'h10, -1);
        chk_ev("t3_w1", 1, 2'd1, 8'h20, (out_log.size() > 0) ? out_log[0].cyc + 1 : -1);
        chk_ev("t3_w2", 2, 2'd2, 8'h30, (out_log.size() > 0) ? out_log[0].cyc + 2 : -1);
        chk_ev("t3_w3", 3, 2'd3, 8'h40, (out_log.size() > 0) ? out_log[0].cyc + 3 : -1);
        drive(4'b1001, 8'h0A, 8'h00, 8'h00, 8'h3A, 1'b0);
        idle(4);
        chk_ev("t3_w4", 4, 2'd0, 8'h0A, -1);
        chk_ev("t3_w5", 5, 2'd3, 8'h3A, -1);
        chk("t3_count", out_log.size(), 6);

        // 4: overflow of lane 2 with no consumer
        for (int k = 1; k <= 5; k++) begin
            drive(4'b0100, 8'h00, 8'h00, 8'(k), 8'h00, 1'b0);
            @(posedge clk_f);
            #2;
            chk($sformatf("t4_af2_push%0d", k), almost_full[2], (k >= 3));
            chk($sformatf("t4_ovf2_push%0d", k), overflow_err[2], (k == 5));
        end
        out_log.delete();
        idle(7);
        chk("t4_count", out_log.size(), 4);
        for (int k = 0; k < 4; k++) chk_ev($sformatf("t4_w%0d", k), k, 2'd2, 8'(k + 1), -1);
        chk("t4_ovf_sticky", overflow_err, 4'b0100);

        // 5: push into a full lane while it pops
        pulse_reset();
        out_log.delete();
        for (int k = 0; k < 4; k++) drive(4'b0001, 8'hB0 + 8'(k), 8'h00, 8'h00, 8'h00, 1'b0);
        drive(4'b0001, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1);
        @(posedge clk_f);
        #2;
        chk("t5_ovf0", overflow_err[0], 1'b1);
        chk("t5_first_pop", data_out, 8'hB0);
        idle(6);
        chk("t5_count", out_log.size(), 4);
        for (int k = 0; k < 4; k++) chk_ev($sformatf("t5_w%0d", k), k, 2'd0, 8'hB0 + 8'(k), -1);

        // 6: reset with words buffered
        drive(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        drive(4'b1111, 8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
        @(negedge clk_f);
        valid_0_cond = 1'b0; valid_1_cond = 1'b0; valid_2_cond = 1'b0; valid_3_cond = 1'b0;
        #2 reset_L = 1'b0;
        #2;
        chk("t6_empty", empty, 4'hF);
        chk("t6_af", almost_full, 4'h0);
        chk("t6_ovf", overflow_err, 4'h0);
        chk("t6_valid", valid_out, 1'b0);
        chk("t6_data", data_out, 8'h00);
        #3 reset_L = 1'b1;
        out_log.delete();
        idle(5);
        chk("t6_no_output", out_log.size(), 0);

        // Random traffic: heavy overload first, then light load
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = (i < 1500) ? 60 : 20;
            for (int l = 0; l < 4; l++) vm[l] = ($urandom_range(99) < p);
            if (i == 2200) pulse_reset();
            drive(vm, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(99) < ((i < 1500) ? 50 : 80)));
        end
        idle(25);
        chk("final_drained", empty, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
